// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine: FSM states, mode encoding,
// guard width, elaboration-time arctangent table generator and the gain-compensation terms.
package cordic_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StIter,
        StComp,
        StDone
    } state_e;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    localparam int unsigned GUARD_BITS = 2;

    // K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13; K_NEG bit k marks a subtracted term
    localparam int unsigned K_NTERMS = 5;
    localparam int unsigned K_SHIFT [K_NTERMS] = '{1, 3, 6, 9, 13};
    localparam logic [K_NTERMS-1:0] K_NEG = 5'b11100;

    // round(atan(2^-i) / pi * 2^(width-1)), via a Q56 arctangent series and long division by pi
    function automatic longint unsigned atan_lut(input int i, input int width);
        longint unsigned pi_q56;
        longint          acc;
        longint          term;
        longint unsigned rem;
        longint unsigned q;
        int              sh;
        pi_q56 = 64'h0324_3F6A_8885_A308;
        if (i == 0) begin
            return longint'(1) << (width - 3);
        end
        acc = 0;
        for (int k = 0; k < 32; k++) begin
            sh = 56 - i * (2 * k + 1);
            if (sh >= 0) begin
                term = (longint'(1) << sh) / longint'(2 * k + 1);
                acc  = (k % 2 == 1) ? acc - term : acc + term;
            end
        end
        rem = longint'(acc);
        q   = 0;
        for (int b = 0; b < width; b++) begin
            rem = rem << 1;
            q   = q << 1;
            if (rem >= pi_q56) begin
                rem = rem - pi_q56;
                q   = q | 64'd1;
            end
        end
        return (q + 64'd1) >> 1;
    endfunction

endpackage

// File: rtl/cordic_iter_engine_if.sv
// Valid/ready stream bundle for the CORDIC engine: operand input side and result output side.
interface cordic_iter_engine_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [DATA_WIDTH-1:0] in_x;
    logic [DATA_WIDTH-1:0] in_y;
    logic [DATA_WIDTH-1:0] in_z;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_x;
    logic [DATA_WIDTH-1:0] out_y;
    logic [DATA_WIDTH-1:0] out_z;
    logic                  out_sat;

    modport master (
        output in_valid, in_mode, in_x, in_y, in_z, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_z, out_sat
    );

    modport slave (
        input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
        output in_ready, out_valid, out_x, out_y, out_z, out_sat
    );
endinterface

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation; the engine reuses a single instance every ITER cycle.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IterW      = 4,
    localparam int unsigned W         = DATA_WIDTH + GUARD_BITS
) (
    input  logic signed [W-1:0]          x_i,
    input  logic signed [W-1:0]          y_i,
    input  logic        [DATA_WIDTH-1:0] z_i,
    input  logic        [IterW-1:0]      iter_i,
    input  logic                         mode_i,
    input  logic        [DATA_WIDTH-1:0] atan_i,
    output logic signed [W-1:0]          x_o,
    output logic signed [W-1:0]          y_o,
    output logic        [DATA_WIDTH-1:0] z_o
);
    logic                ccw;
    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;

    always_comb begin
        ccw  = (mode_i == MODE_ROT) ? ~z_i[DATA_WIDTH-1] : y_i[W-1];
        x_sh = x_i >>> iter_i;
        y_sh = y_i >>> iter_i;
        if (ccw) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_i;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_i;
        end
    end
endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative rotation/vectoring CORDIC with quadrant fold, saturation and stream handshakes.
// Optional unity-gain COMP state is enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_ITER     = 13
) (
    input  logic                i_clk,
    input  logic                rst,
    cordic_iter_engine_if.slave stream_io,
    output logic                busy
);
    localparam int unsigned W    = DATA_WIDTH + GUARD_BITS;
    localparam int unsigned CntW = $clog2(N_ITER + 1);

    if (N_ITER < 4 || N_ITER > DATA_WIDTH - 1) begin : g_bad_n_iter
        $error("N_ITER must lie in [4, DATA_WIDTH-1]");
    end

    typedef logic [N_ITER-1:0][DATA_WIDTH-1:0] atan_tab_t;

    function automatic atan_tab_t build_atan();
        atan_tab_t t;
        for (int k = 0; k < int'(N_ITER); k++) begin
            t[k] = DATA_WIDTH'(atan_lut(k, int'(DATA_WIDTH)));
        end
        return t;
    endfunction

    localparam atan_tab_t ATAN = build_atan();

    localparam logic [DATA_WIDTH-1:0] HALF_PI = {2'b01, {(DATA_WIDTH-2){1'b0}}};
    localparam logic signed [W-1:0] SAT_MAX = {{(GUARD_BITS+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {{(GUARD_BITS+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic [DATA_WIDTH:0] saturate(input logic signed [W-1:0] v);
        if (v > SAT_MAX) return {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        if (v < SAT_MIN) return {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        return {1'b0, v[DATA_WIDTH-1:0]};
    endfunction

    state_e                     state_q;
    logic signed [W-1:0]        x_q, y_q;
    logic [DATA_WIDTH-1:0]      z_q;
    logic                       mode_q;
    logic [CntW-1:0]            iter_q;
    logic [DATA_WIDTH-1:0]      out_x_q, out_y_q, out_z_q;
    logic                       out_sat_q;

    logic signed [W-1:0]        fold_x_d, fold_y_d, stage_x, stage_y, fin_x, fin_y;
    logic [DATA_WIDTH-1:0]      fold_z_d, stage_z, atan_cur;
    logic [DATA_WIDTH:0]        sat_x, sat_y;

    always_comb begin
        fold_x_d = x_q;
        fold_y_d = y_q;
        fold_z_d = z_q;
        if (mode_q == MODE_ROT) begin
            if (z_q[DATA_WIDTH-1 -: 2] == 2'b01 && z_q != HALF_PI) begin
                fold_x_d = -y_q;
                fold_y_d = x_q;
                fold_z_d = z_q - HALF_PI;
            end else if (z_q[DATA_WIDTH-1 -: 2] == 2'b10) begin
                fold_x_d = y_q;
                fold_y_d = -x_q;
                fold_z_d = z_q + HALF_PI;
            end
        end else if (x_q[W-1]) begin
            if (!y_q[W-1]) begin
                fold_x_d = y_q;
                fold_y_d = -x_q;
                fold_z_d = z_q + HALF_PI;
            end else begin
                fold_x_d = -y_q;
                fold_y_d = x_q;
                fold_z_d = z_q - HALF_PI;
            end
        end
    end

    always_comb begin
        atan_cur = '0;
        for (int k = 0; k < int'(N_ITER); k++) begin
            if (iter_q == CntW'(k)) atan_cur = ATAN[k];
        end
    end

    cordic_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .IterW     (CntW)
    ) u_stage (
        .x_i   (x_q),
        .y_i   (y_q),
        .z_i   (z_q),
        .iter_i(iter_q),
        .mode_i(mode_q),
        .atan_i(atan_cur),
        .x_o   (stage_x),
        .y_o   (stage_y),
        .z_o   (stage_z)
    );

`ifdef CORDIC_GAIN_COMP_EN
    function automatic logic signed [W-1:0] scale_k(input logic signed [W-1:0] v);
        logic signed [W-1:0] acc;
        acc = '0;
        for (int k = 0; k < int'(K_NTERMS); k++) begin
            acc = K_NEG[k] ? acc - (v >>> K_SHIFT[k]) : acc + (v >>> K_SHIFT[k]);
        end
        return acc;
    endfunction

    assign fin_x = scale_k(x_q);
    assign fin_y = scale_k(y_q);
`else
    assign fin_x = x_q;
    assign fin_y = y_q;
`endif

    assign sat_x = saturate(fin_x);
    assign sat_y = saturate(fin_y);

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            mode_q    <= MODE_ROT;
            iter_q    <= '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_z_q   <= '0;
            out_sat_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (stream_io.in_valid) begin
                        x_q     <= {{GUARD_BITS{stream_io.in_x[DATA_WIDTH-1]}}, stream_io.in_x};
                        y_q     <= {{GUARD_BITS{stream_io.in_y[DATA_WIDTH-1]}}, stream_io.in_y};
                        z_q     <= stream_io.in_z;
                        mode_q  <= stream_io.in_mode;
                        iter_q  <= '0;
                        state_q <= StPre;
                    end
                end
                StPre: begin
                    x_q     <= fold_x_d;
                    y_q     <= fold_y_d;
                    z_q     <= fold_z_d;
                    state_q <= StIter;
                end
                StIter: begin
                    // The beat after the last micro-rotation registers the result
                    if (iter_q == CntW'(N_ITER)) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state_q   <= StComp;
`else
                        out_x_q   <= sat_x[DATA_WIDTH-1:0];
                        out_y_q   <= sat_y[DATA_WIDTH-1:0];
                        out_z_q   <= z_q;
                        out_sat_q <= sat_x[DATA_WIDTH] | sat_y[DATA_WIDTH];
                        state_q   <= StDone;
`endif
                    end else begin
                        x_q    <= stage_x;
                        y_q    <= stage_y;
                        z_q    <= stage_z;
                        iter_q <= iter_q + CntW'(1);
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                StComp: begin
                    out_x_q   <= sat_x[DATA_WIDTH-1:0];
                    out_y_q   <= sat_y[DATA_WIDTH-1:0];
                    out_z_q   <= z_q;
                    out_sat_q <= sat_x[DATA_WIDTH] | sat_y[DATA_WIDTH];
                    state_q   <= StDone;
                end
`endif
                StDone: begin
                    if (stream_io.out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stream_io.in_ready  = (state_q == StIdle);
    assign stream_io.out_valid = (state_q == StDone);
    assign stream_io.out_x     = out_x_q;
    assign stream_io.out_y     = out_y_q;
    assign stream_io.out_z     = out_z_q;
    assign stream_io.out_sat   = out_sat_q;
    assign busy                = (state_q != StIdle);
endmodule
